// File: rtl/bus_ctrl_if.sv
// Mux-side bus bundle for bus_ctrl: register/immediate data out,
// one-hot mux selects out, mux result and control in.
interface bus_ctrl_if #(
  parameter int W = 16
);
  logic         run;
  logic [W-1:0] din;
  logic [W-1:0] bus;
  logic [W-1:0] imediat;
  logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [W-1:0] r;
  logic         imediat_select;
  logic         r0_select, r1_select, r2_select, r3_select;
  logic         r4_select, r5_select, r6_select, r7_select;
  logic         r_select;
  logic         done;

  modport slave (
    input  run, din, bus,
    output imediat, r0, r1, r2, r3, r4, r5, r6, r7, r,
    output imediat_select, r0_select, r1_select, r2_select, r3_select,
    output r4_select, r5_select, r6_select, r7_select, r_select, done
  );

  modport master (
    output run, din, bus,
    input  imediat, r0, r1, r2, r3, r4, r5, r6, r7, r,
    input  imediat_select, r0_select, r1_select, r2_select, r3_select,
    input  r4_select, r5_select, r6_select, r7_select, r_select, done
  );
endinterface

// File: rtl/bus_ctrl.sv
// Register bank (R0..R7, A, G, IR) and T0..T3 sequencer driving the
// shared 16-bit bus mux selects; captures the mux output into registers.
module bus_ctrl #(
  parameter int W   = 16,
  parameter int IRW = 9
) (
  input  logic       clock,
  input  logic       resetn,
  bus_ctrl_if.slave  bif
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_regs [8];
  logic [W-1:0]   r_a, r_g;
  logic [IRW-1:0] r_ir;

  logic [2:0] w_op, w_x, w_y;
  logic [7:0] w_rsel;
  logic       w_imm_sel, w_g_sel, w_done;
  logic       w_wr_rx, w_ld_a, w_ld_g;

  assign w_op = r_ir[8:6];
  assign w_x  = r_ir[5:3];
  assign w_y  = r_ir[2:0];

  always_comb begin
    w_next    = r_state;
    w_rsel    = '0;
    w_imm_sel = 1'b0;
    w_g_sel   = 1'b0;
    w_done    = 1'b0;
    w_wr_rx   = 1'b0;
    w_ld_a    = 1'b0;
    w_ld_g    = 1'b0;
    unique case (r_state)
      T0: if (bif.run) w_next = T1;
      T1: begin
        w_next = T0;
        case (w_op)
          3'b000: begin
            w_rsel  = 8'(1) << w_y;
            w_wr_rx = 1'b1;
            w_done  = 1'b1;
          end
          3'b001: begin
            w_imm_sel = 1'b1;
            w_wr_rx   = 1'b1;
            w_done    = 1'b1;
          end
          3'b010, 3'b011: begin
            w_rsel = 8'(1) << w_x;
            w_ld_a = 1'b1;
            w_next = T2;
          end
          default: w_done = 1'b1;
        endcase
      end
      T2: begin
        w_rsel = 8'(1) << w_y;
        w_ld_g = 1'b1;
        w_next = T3;
      end
      T3: begin
        w_g_sel = 1'b1;
        w_wr_rx = 1'b1;
        w_done  = 1'b1;
        w_next  = T0;
      end
      default: w_next = T0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= T0;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
      r_a  <= '0;
      r_g  <= '0;
      r_ir <= '0;
    end else begin
      if (r_state == T0 && bif.run) r_ir <= bif.din[IRW-1:0];
      if (w_wr_rx) r_regs[w_x] <= bif.bus;
      if (w_ld_a)  r_a <= bif.bus;
      // T2 is only reached from add/sub; opcode bit 0 separates them.
      if (w_ld_g)  r_g <= w_op[0] ? (r_a - bif.bus) : (r_a + bif.bus);
    end
  end

  assign bif.imediat        = bif.din;
  assign bif.r0             = r_regs[0];
  assign bif.r1             = r_regs[1];
  assign bif.r2             = r_regs[2];
  assign bif.r3             = r_regs[3];
  assign bif.r4             = r_regs[4];
  assign bif.r5             = r_regs[5];
  assign bif.r6             = r_regs[6];
  assign bif.r7             = r_regs[7];
  assign bif.r              = r_g;
  assign bif.imediat_select = w_imm_sel;
  assign bif.r0_select      = w_rsel[0];
  assign bif.r1_select      = w_rsel[1];
  assign bif.r2_select      = w_rsel[2];
  assign bif.r3_select      = w_rsel[3];
  assign bif.r4_select      = w_rsel[4];
  assign bif.r5_select      = w_rsel[5];
  assign bif.r6_select      = w_rsel[6];
  assign bif.r7_select      = w_rsel[7];
  assign bif.r_select       = w_g_sel;
  assign bif.done           = w_done;

endmodule

// File: tb/tb_bus_ctrl.sv
// Randomized scoreboard bench for bus_ctrl: the bench models the external mux,
// predicts select sequences and register contents per instruction.
module tb_bus_ctrl;
  localparam int W = 16;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  bus_ctrl_if #(.W(W)) bif ();

  bus_ctrl #(.W(W), .IRW(9)) dut (
    .clock (clock),
    .resetn(resetn),
    .bif   (bif)
  );

  always #5 clock = ~clock;

  // bit 0..7 = r0..r7 selects, bit 8 = G select, bit 9 = immediate select
  logic [9:0]   sel_v;
  logic [W-1:0] dut_r [9];
  assign sel_v = {bif.imediat_select, bif.r_select,
                  bif.r7_select, bif.r6_select, bif.r5_select, bif.r4_select,
                  bif.r3_select, bif.r2_select, bif.r1_select, bif.r0_select};

  always_comb begin
    dut_r[0] = bif.r0; dut_r[1] = bif.r1; dut_r[2] = bif.r2;
    dut_r[3] = bif.r3; dut_r[4] = bif.r4; dut_r[5] = bif.r5;
    dut_r[6] = bif.r6; dut_r[7] = bif.r7; dut_r[8] = bif.r;
  end

  // External 16-bit mux: selected source onto bus.
  always_comb begin
    bif.bus = '0;
    if (sel_v[9]) bif.bus = bif.imediat;
    if (sel_v[8]) bif.bus = bif.r;
    for (int i = 0; i < 8; i++) if (sel_v[i]) bif.bus = dut_r[i];
  end

  typedef struct packed {
    logic [1:0]            n;
    logic [2:0][9:0]       tr;
    logic [8:0][W-1:0]     regs;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_r [8];
  logic [W-1:0] m_g;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: collects select activity of each instruction, compares on done,
  // and checks the register file on the following cycle.
  logic [9:0] got_tr[$];
  exp_t       cur;
  bit         pend = 0;

  always @(negedge clock) begin
    if (!resetn) begin
      got_tr.delete();
      pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        for (int i = 0; i < 9; i++) chk($sformatf("reg%0d", i), 32'(dut_r[i]), 32'(cur.regs[i]));
      end
      chk("onehot", 32'($countones(sel_v) <= 1), 32'd1);
      if (sel_v != '0 || bif.done) got_tr.push_back(sel_v);
      if (bif.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("trace_len", 32'(got_tr.size()), 32'(cur.n));
          if (got_tr.size() == int'(cur.n))
            for (int i = 0; i < int'(cur.n); i++)
              chk($sformatf("trace%0d", i), 32'(got_tr[i]), 32'(cur.tr[i]));
          pend = 1;
        end
        got_tr.delete();
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic [W-1:0] imm);
    exp_t         e;
    logic [W-1:0] g;
    bit           got;
    e = '0;
    case (op)
      3'd0: begin e.n = 1; e.tr[0] = 10'(1) << y; m_r[x] = m_r[y]; end
      3'd1: begin e.n = 1; e.tr[0] = 10'h200; m_r[x] = imm; end
      3'd2, 3'd3: begin
        g = (op == 3'd2) ? m_r[x] + m_r[y] : m_r[x] - m_r[y];
        e.n = 3; e.tr[0] = 10'(1) << x; e.tr[1] = 10'(1) << y; e.tr[2] = 10'h100;
        m_g = g; m_r[x] = g;
      end
      default: begin e.n = 1; e.tr[0] = '0; end
    endcase
    for (int i = 0; i < 8; i++) e.regs[i] = m_r[i];
    e.regs[8] = m_g;
    exp_q.push_back(e);

    @(negedge clock);
    bif.run = 1'b1;
    bif.din = {7'($urandom), op, x, y};
    @(posedge clock);
    #1;
    bif.run = 1'($urandom);
    bif.din = (op == 3'd1) ? imm : W'($urandom);
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bif.done) begin got = 1; break; end
      bif.din = W'($urandom);
      bif.run = 1'($urandom);
    end
    bif.run = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel"}, 32'(sel_v), 32'd0);
    chk({tag, "_done"}, 32'(bif.done), 32'd0);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_reg%0d", tag, i), 32'(dut_r[i]), 32'd0);
  endtask

  initial begin
    bif.run = 1'b0;
    bif.din = '0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_g = '0;
    #12;
    check_zero("reset");
    #11 resetn = 1'b1;

    repeat (10) begin
      @(negedge clock);
      chk("idle_sel", 32'(sel_v), 32'd0);
      chk("idle_done", 32'(bif.done), 32'd0);
      chk("idle_imm", 32'(bif.imediat), 32'(bif.din));
      for (int i = 0; i < 9; i++) chk($sformatf("idle_reg%0d", i), 32'(dut_r[i]), 32'd0);
    end

    issue(3'd1, 3'd3, 3'd0, 16'h1234);
    @(negedge clock);
    chk("mvi_r3", 32'(bif.r3), 32'h1234);

    issue(3'd0, 3'd0, 3'd3, 16'h0);
    @(negedge clock);
    chk("mv_r0", 32'(bif.r0), 32'h1234);

    issue(3'd1, 3'd1, 3'd0, 16'h0005);
    issue(3'd1, 3'd2, 3'd0, 16'hFFFF);
    issue(3'd2, 3'd1, 3'd2, 16'h0);
    @(negedge clock);
    chk("add_r1", 32'(bif.r1), 32'h0004);

    issue(3'd1, 3'd4, 3'd0, 16'h0007);
    issue(3'd3, 3'd4, 3'd4, 16'h0);
    @(negedge clock);
    chk("sub_r4", 32'(bif.r4), 32'h0000);
    issue(3'd1, 3'd5, 3'd0, 16'h8000);
    issue(3'd2, 3'd5, 3'd5, 16'h0);
    @(negedge clock);
    chk("add_wrap_r5", 32'(bif.r5), 32'h0000);
    issue(3'd5, 3'd1, 3'd2, 16'h0);

    // Abort an add in T2 with an asynchronous reset.
    @(negedge clock);
    bif.run = 1'b1;
    bif.din = {7'd0, 3'b010, 3'd2, 3'd3};
    @(posedge clock);
    #1 bif.run = 1'b0;
    @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_zero("abort");
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_g = '0;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    issue(3'd1, 3'd6, 3'd0, 16'hBEEF);
    @(negedge clock);
    chk("post_abort_r6", 32'(bif.r6), 32'hBEEF);

    repeat (150) issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), W'($urandom));
    repeat (3) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
